// File: rtl/dmem_bridge_pkg.sv
// Shared encodings for the data-memory bridge: access sizes, fault codes,
// FSM states and the alignment rule used when a request is accepted.
package dmem_bridge_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_BUSERR   = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    DMB_IDLE = 2'd0,
    DMB_BUS  = 2'd1,
    DMB_DONE = 2'd2
  } dmb_state_e;

  // Halfwords need an even address, words (and the size-3 alias) need a
  // word-aligned address; bytes are always aligned.
  function automatic logic dmb_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_SIZE_B: mis = 1'b0;
      MEM_SIZE_H: mis = off[0];
      default:    mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_bridge_lane.sv
// Byte-lane logic for the data-memory bridge: store lane steering
// (byte enables plus replicated write data) and load lane extraction
// with zero/sign extension. Purely combinational.
module mem_lane
  import dmem_bridge_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_dout,
  output logic [3:0]  st_sel,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_sign,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store steering: replicate the right-justified data into every lane and
  // enable only the lanes addressed by the access.
  always_comb begin
    st_sel   = 4'b1111;
    st_wdata = st_dout;
    case (st_size)
      MEM_SIZE_B: begin
        st_sel   = 4'b0001 << st_off;
        st_wdata = {4{st_dout[7:0]}};
      end
      MEM_SIZE_H: begin
        st_sel   = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_dout[15:0]}};
      end
      default: begin
        st_sel   = 4'b1111;
        st_wdata = st_dout;
      end
    endcase
  end

  // Load extraction: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    ld_data = ld_rdata;
    ld_byte = ld_rdata[7:0];
    case (ld_off)
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      2'd3:    ld_byte = ld_rdata[31:24];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      MEM_SIZE_B: ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
      MEM_SIZE_H: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
      default:    ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge behind the MEM stage: turns a single-cycle load/store
// request into a req/ack bus transaction, stalls the pipeline until it
// completes, returns extended load data and reports misalignment, bus
// error and timeout faults.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic        mem_en,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  dmb_state_e       state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_sel_q, bus_sel_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      mem_din_q, mem_din_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  // Request attributes latched at issue so extraction ignores live inputs.
  logic [1:0]       ld_off_q, ld_off_d;
  logic [1:0]       ld_size_q, ld_size_d;
  logic             ld_sign_q, ld_sign_d;

  logic             access;
  logic             misaligned;
  logic [3:0]       st_sel;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  assign access     = mem_ren | mem_wen;
  assign misaligned = dmb_misaligned(mem_size, mem_addr[1:0]);
  assign cnt_inc    = cnt_q + 1'b1;

  mem_lane u_lane (
    .st_off   (mem_addr[1:0]),
    .st_size  (mem_size),
    .st_dout  (mem_dout),
    .st_sel   (st_sel),
    .st_wdata (st_wdata),
    .ld_off   (ld_off_q),
    .ld_size  (ld_size_q),
    .ld_sign  (ld_sign_q),
    .ld_rdata (bus_rdata),
    .ld_data  (ld_data)
  );

  // Next-state and register-update logic for the IDLE/BUS/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    mem_din_d    = mem_din_q;
    fault_code_d = fault_code_q;
    fault_addr_d = fault_addr_q;
    ld_off_d     = ld_off_q;
    ld_size_d    = ld_size_q;
    ld_sign_d    = ld_sign_q;

    case (state_q)
      DMB_IDLE: begin
        if (access) begin
          if (misaligned) begin
            fault_code_d = FAULT_MISALIGN;
            fault_addr_d = mem_addr;
            state_d      = DMB_DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wen;
            bus_addr_d  = {mem_addr[31:2], 2'b00};
            bus_sel_d   = st_sel;
            bus_wdata_d = st_wdata;
            ld_off_d    = mem_addr[1:0];
            ld_size_d   = mem_size;
            ld_sign_d   = mem_sign;
            cnt_d       = '0;
            state_d     = DMB_BUS;
          end
        end
      end
      DMB_BUS: begin
        // Error outranks a simultaneous ack.
        if (bus_err) begin
          bus_req_d    = 1'b0;
          fault_code_d = FAULT_BUSERR;
          fault_addr_d = {bus_addr_q[31:2], ld_off_q};
          state_d      = DMB_DONE;
        end else if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            mem_din_d = ld_data;
          end
          state_d = DMB_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIM) begin
            bus_req_d    = 1'b0;
            fault_code_d = FAULT_TIMEOUT;
            fault_addr_d = {bus_addr_q[31:2], ld_off_q};
            state_d      = DMB_DONE;
          end
        end
      end
      DMB_DONE: begin
        if (mem_en) begin
          fault_code_d = FAULT_NONE;
          state_d      = DMB_IDLE;
        end
      end
      default: begin
        state_d = DMB_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns every output to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= DMB_IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_sel_q    <= '0;
      bus_wdata_q  <= '0;
      mem_din_q    <= '0;
      fault_code_q <= FAULT_NONE;
      fault_addr_q <= '0;
      ld_off_q     <= '0;
      ld_size_q    <= '0;
      ld_sign_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_wdata_q  <= bus_wdata_d;
      mem_din_q    <= mem_din_d;
      fault_code_q <= fault_code_d;
      fault_addr_q <= fault_addr_d;
      ld_off_q     <= ld_off_d;
      ld_size_q    <= ld_size_d;
      ld_sign_q    <= ld_sign_d;
    end
  end

  assign mem_stall  = ((state_q == DMB_IDLE) & access) | (state_q == DMB_BUS);
  assign mem_fault  = (fault_code_q != FAULT_NONE);
  assign mem_din    = mem_din_q;
  assign fault_code = fault_code_q;
  assign fault_addr = fault_addr_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_sel    = bus_sel_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the MEM stage of the 5-stage MIPS pipeline datapath.
- Converts the single-cycle mem_ren/mem_wen/mem_addr/mem_dout request into a req/ack data-bus transaction with byte/halfword lane steering.
- Returns the load data on mem_din.
- Raises a pipeline stall until the access completes, and reports alignment, bus-error and timeout faults to the CP0/control logic.

Parameters:
- TIMEOUT, 64, cycles in BUS state without ack/err before a timeout fault; 1..255.
- TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  main clock
- rst_n  in  1  synchronous active-low reset
- mem_ren  in  1  load request from MEM stage
- mem_wen  in  1  store request from MEM stage
- mem_addr  in  32  byte address (ALU result)
- mem_dout  in  32  store data, right-justified
- mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word
- mem_sign  in  1  load sign-extension (lb/lh = 1, lbu/lhu = 0)
- mem_en  in  1  MEM→WB advance strobe from the controller
- mem_din  out  32  load result, extended
- mem_stall  out  1  hold IF..MEM and bubble WB
- mem_fault  out  1  access finished with a fault; valid in DONE
- fault_code  out  2  0 = none, 1 = misaligned, 2 = bus error, 3 = timeout
- fault_addr  out  32  faulting byte address
- bus_req  out  1  transaction request
- bus_we  out  1  write enable
- bus_addr  out  32  word-aligned address ({mem_addr[31:2], 2'b00})
- bus_sel  out  4  byte lane enables, little-endian
- bus_wdata  out  32  lane-replicated write data
- bus_ack  in  1  transaction complete
- bus_err  in  1  transaction failed; completes like ack
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset state: every register output is 0 (bus_req, bus_we, bus_addr, bus_sel, bus_wdata, mem_din, mem_fault, fault_code, fault_addr). FSM goes to IDLE and the timeout counter clears.
- Reset mid-transaction: bus_req drops at the reset edge. A late ack/err arriving in IDLE is ignored.
- access = mem_ren | mem_wen. If both are set, the access is a write.
- FSM states: IDLE, BUS, DONE.
- IDLE with access and aligned address:
  - Register bus_req = 1 and bus_we.
  - Register bus_addr, bus_sel and bus_wdata from the current inputs.
  - Clear the counter, then go to BUS.
- IDLE with access and misaligned address (half with addr[0] = 1, or word with addr[1:0] ≠ 0):
  - No bus cycle.
  - Go to DONE with fault_code = 1 and fault_addr = mem_addr.
- BUS:
  - bus_req and all bus_* outputs are held stable.
  - On bus_ack (and no bus_err): capture the extracted load result into mem_din (stores leave mem_din unchanged), deassert bus_req, go to DONE with no fault.
  - On bus_err: go to DONE with fault_code = 2. If ack and err arrive together, err wins.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, deassert bus_req and go to DONE with fault_code = 3.
- DONE:
  - mem_fault = (fault_code ≠ 0). mem_din and the fault outputs are held.
  - On mem_en = 1: go to IDLE and clear fault_code/mem_fault.
  - A new request is evaluated in IDLE on the following cycle.
- mem_stall (combinational) = (IDLE & access) | BUS. It is 0 in DONE. It is 0 in IDLE when there is no access.
- Latency: with ack in the first BUS cycle, the stall lasts 2 cycles and mem_din is valid in the 3rd cycle (DONE).
- Store lane steering:
  - byte: wdata = {4{dout[7:0]}}, sel = 4'b0001 << addr[1:0]
  - half: wdata = {2{dout[15:0]}}, sel = addr[1] ? 4'b1100 : 4'b0011
  - word: wdata = dout, sel = 4'b1111
- Load extraction:
  - byte: lane rdata[8*addr[1:0] +: 8]
  - half: lane rdata[16*addr[1] +: 16]
  - Zero- or sign-extend the selected lane per mem_sign.
- Load extraction uses the addr/size/sign registered at request time, not the live inputs.

Decomposition:
- Shared define header (alongside mips_define.vh) holds:
  - MEM_SIZE_B/H/W
  - FAULT_NONE/MISALIGN/BUSERR/TIMEOUT
  - DMB_IDLE/BUS/DONE state encodings
- One natural combinational sub-module, mem_lane: store steering (sel, wdata) and load extraction. The FSM, counter and registers stay in dmem_bridge.

Test Plan:
- sw addr 0x100, dout 0xDEADBEEF, ack on 1st BUS cycle → bus_sel 4'b1111, bus_wdata 0xDEADBEEF, bus_we 1, stall high for exactly 2 cycles, mem_fault 0.
- lb addr 0x203, sign 1, rdata 0x80FF_0000, ack after 3 BUS cycles → mem_din 0xFFFFFF80, stall 5 cycles. lbu at the same address → 0x00000080.
- sh addr 0x12, dout 0x0000_1234 → bus_sel 4'b1100, bus_wdata 0x12341234. lh addr 0x11 → no bus_req, fault_code 1, fault_addr 0x11, stall 1 cycle.
- lw with no ack, TIMEOUT = 4 → bus_req high for 4 cycles then low, fault_code 3. bus_err with ack in the same cycle → fault_code 2.
- DONE with mem_en held 0 for 3 cycles → mem_din/fault held, no new bus_req. mem_en 1 → IDLE, and a back-to-back lw issues bus_req the next cycle.
- rst_n low during BUS → next edge bus_req 0, state IDLE. An ack arriving one cycle later has no effect; mem_din stays 0.
